// File: rtl/uart_paddle_ctrl_if.sv
// Byte/frame inputs and paddle command outputs of the UART paddle controller.
// The slave modport is the controller side; master is the driver/observer side.
interface uart_paddle_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_tick;
  logic       p1_up;
  logic       p1_down;
  logic       p2_up;
  logic       p2_down;
  logic       pause;
  logic       game_reset;
  logic       cmd_err;

  modport master (
    output rx_data, rx_valid, frame_tick,
    input  p1_up, p1_down, p2_up, p2_down, pause, game_reset, cmd_err
  );

  modport slave (
    input  rx_data, rx_valid, frame_tick,
    output p1_up, p1_down, p2_up, p2_down, pause, game_reset, cmd_err
  );
endinterface

// File: rtl/uart_paddle_ctrl.sv
// Decodes 0xA5-prefixed UART commands into paddle hold/pause/reset controls.
// Optional macro CMD_TIMEOUT_EN adds a WAIT_CMD inactivity timeout.
module uart_paddle_ctrl #(
  parameter int unsigned HOLD_FRAMES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input logic               clk25MHz,
  input logic               rst_n,
  uart_paddle_ctrl_if.slave bus
);

  localparam logic [7:0] Hdr    = 8'hA5;
  localparam logic [7:0] HoldLd = 8'(HOLD_FRAMES);

  if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
  begin : g_param_chk
    $error("uart_paddle_ctrl: HOLD_FRAMES or TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {StWaitHdr, StWaitCmd, StExec} state_e;

  state_e          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [1:0][7:0] cnt_q, cnt_d;
  logic [1:0]      up_q, up_d, dn_q, dn_d;
  logic            pause_q, pause_d;
  logic            game_reset_q, game_reset_d;
  logic            cmd_err_q, cmd_err_d;

`ifdef CMD_TIMEOUT_EN
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cnt_d        = cnt_q;
    up_d         = up_q;
    dn_d         = dn_q;
    pause_d      = pause_q;
    game_reset_d = 1'b0;
    cmd_err_d    = 1'b0;
`ifdef CMD_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif

    // Frame aging first so that a same-cycle EXEC load below overrides it.
    if (!pause_q && bus.frame_tick) begin
      for (int p = 0; p < 2; p++) begin
        if (cnt_q[p] != 8'd0) begin
          cnt_d[p] = cnt_q[p] - 8'd1;
          if (cnt_q[p] == 8'd1) begin
            up_d[p] = 1'b0;
            dn_d[p] = 1'b0;
          end
        end
      end
    end

    case (state_q)
      StWaitHdr: begin
        if (bus.rx_valid && bus.rx_data == Hdr) begin
          state_d = StWaitCmd;
`ifdef CMD_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end

      StWaitCmd: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == Hdr) begin
`ifdef CMD_TIMEOUT_EN
            tmo_d = '0;
`endif
          end else begin
            cmd_d   = bus.rx_data;
            state_d = StExec;
          end
        end
`ifdef CMD_TIMEOUT_EN
        else if (tmo_q == TmoLast) begin
          state_d   = StWaitHdr;
          cmd_err_d = 1'b1;
          tmo_d     = '0;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end

      StExec: begin
        state_d   = StWaitHdr;
        cmd_err_d = bus.rx_valid;
        case (cmd_q)
          8'h01: if (!pause_q) begin cnt_d[0] = HoldLd; up_d[0] = 1'b1; dn_d[0] = 1'b0; end
          8'h02: if (!pause_q) begin cnt_d[0] = HoldLd; up_d[0] = 1'b0; dn_d[0] = 1'b1; end
          8'h03: if (!pause_q) begin cnt_d[1] = HoldLd; up_d[1] = 1'b1; dn_d[1] = 1'b0; end
          8'h04: if (!pause_q) begin cnt_d[1] = HoldLd; up_d[1] = 1'b0; dn_d[1] = 1'b1; end
          8'h10: begin
            pause_d = ~pause_q;
            up_d    = '0;
            dn_d    = '0;
            // Leaving pause restarts hold counters from zero.
            if (pause_q) cnt_d = '0;
          end
          8'h20: begin
            game_reset_d = 1'b1;
            pause_d      = 1'b0;
            cnt_d        = '0;
            up_d         = '0;
            dn_d         = '0;
          end
          default: cmd_err_d = 1'b1;
        endcase
      end

      default: state_d = StWaitHdr;
    endcase
  end

  always_ff @(posedge clk25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StWaitHdr;
      cmd_q        <= 8'h00;
      cnt_q        <= '0;
      up_q         <= '0;
      dn_q         <= '0;
      pause_q      <= 1'b0;
      game_reset_q <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cnt_q        <= cnt_d;
      up_q         <= up_d;
      dn_q         <= dn_d;
      pause_q      <= pause_d;
      game_reset_q <= game_reset_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

`ifdef CMD_TIMEOUT_EN
  always_ff @(posedge clk25MHz or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

  assign bus.p1_up      = up_q[0];
  assign bus.p1_down    = dn_q[0];
  assign bus.p2_up      = up_q[1];
  assign bus.p2_down    = dn_q[1];
  assign bus.pause      = pause_q;
  assign bus.game_reset = game_reset_q;
  assign bus.cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_uart_paddle_ctrl.sv
// Directed self-checking bench for uart_paddle_ctrl (HOLD_FRAMES=4, TIMEOUT_CYCLES=10).
// Output vector order: {p1_up, p1_down, p2_up, p2_down, pause, game_reset, cmd_err}.
module tb_uart_paddle_ctrl;

  logic clk25MHz = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk25MHz = ~clk25MHz;

  uart_paddle_ctrl_if bus ();

  uart_paddle_ctrl #(
    .HOLD_FRAMES   (4),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk25MHz(clk25MHz),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  localparam logic [6:0] None = 7'h00;
  localparam logic [6:0] P1U  = 7'h40;
  localparam logic [6:0] P1D  = 7'h20;
  localparam logic [6:0] P2U  = 7'h10;
  localparam logic [6:0] P2D  = 7'h08;
  localparam logic [6:0] Pau  = 7'h04;
  localparam logic [6:0] Grs  = 7'h02;
  localparam logic [6:0] Err  = 7'h01;

  int tests_run    = 0;
  int tests_failed = 0;

  wire [6:0] outs = {bus.p1_up, bus.p1_down, bus.p2_up, bus.p2_down,
                     bus.pause, bus.game_reset, bus.cmd_err};

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk25MHz);
    #1;
  endtask

  // Returns 1 time unit after the edge that sampled the byte.
  task automatic send(input logic [7:0] b);
    cyc();
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    cyc();
    bus.rx_valid = 1'b0;
  endtask

  // Header + command; returns where the command's effect is first visible.
  task automatic cmd(input logic [7:0] b);
    send(8'hA5);
    send(b);
    cyc();
  endtask

  task automatic tick();
    cyc();
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rx_data    = 8'h00;
    bus.rx_valid   = 1'b0;
    bus.frame_tick = 1'b0;
    repeat (2) cyc();
    chk("reset_state", outs, None);
    rst_n = 1'b1;
    cyc();

    send(8'h33);
    cyc();
    chk("stray_byte", outs, None);

    // Basic move, two-cycle latency, expiry after 4 frames.
    send(8'hA5);
    send(8'h01);
    chk("p1_up_early", outs, None);
    cyc();
    chk("p1_up_set", outs, P1U);
    repeat (3) tick();
    chk("p1_up_hold3", outs, P1U);
    tick();
    chk("p1_up_expire", outs, None);

    // Reverse before expiry reloads the counter.
    cmd(8'h01);
    chk("p1_up_again", outs, P1U);
    tick();
    cmd(8'h02);
    chk("p1_reverse", outs, P1D);
    repeat (3) tick();
    chk("p1_down_hold", outs, P1D);
    tick();
    chk("p1_down_expire", outs, None);

    // Unknown command: one-cycle error, other outputs untouched.
    cmd(8'h03);
    chk("p2_up_set", outs, P2U);
    cmd(8'h7F);
    chk("bad_cmd_err", outs, P2U | Err);
    cyc();
    chk("bad_cmd_err_clear", outs, P2U);

    // Byte arriving during EXEC is dropped with an error.
    send(8'hA5);
    cyc();
    bus.rx_data  = 8'h04;
    bus.rx_valid = 1'b1;
    cyc();
    bus.rx_data  = 8'h01;
    cyc();
    bus.rx_valid = 1'b0;
    chk("exec_drop_err", outs, P2D | Err);
    cyc();
    chk("exec_drop_clean", outs, P2D);

    // Pause discards moves; game reset clears pause.
    cmd(8'h10);
    chk("pause_on", outs, Pau);
    cmd(8'h03);
    chk("paused_move_ignored", outs, Pau);
    send(8'hA5);
    send(8'h20);
    cyc();
    chk("game_reset_pulse", outs, Grs);
    cyc();
    chk("game_reset_clear", outs, None);

    // Unpause leaves movement at 0.
    cmd(8'h01);
    chk("pre_pause_move", outs, P1U);
    cmd(8'h10);
    chk("pause_clears_move", outs, Pau);
    repeat (2) tick();
    cmd(8'h10);
    chk("unpause_zero", outs, None);

    // Repeated header resyncs.
    send(8'hA5);
    send(8'hA5);
    send(8'h02);
    cyc();
    chk("resync", outs, P1D);

    // Load and frame_tick together: load wins.
    send(8'hA5);
    cyc();
    bus.rx_data  = 8'h01;
    bus.rx_valid = 1'b1;
    cyc();
    bus.rx_valid   = 1'b0;
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
    chk("load_beats_tick", outs, P1U);
    repeat (3) tick();
    chk("load_tick_hold", outs, P1U);
    tick();
    chk("load_tick_expire", outs, None);

`ifdef CMD_TIMEOUT_EN
    send(8'hA5);
    repeat (9) begin
      cyc();
      chk("tmo_quiet", outs, None);
    end
    cyc();
    chk("tmo_err", outs, Err);
    send(8'h01);
    cyc();
    chk("tmo_cmd_ignored", outs, None);
`else
    send(8'hA5);
    repeat (30) cyc();
    chk("no_tmo_quiet", outs, None);
    send(8'h01);
    cyc();
    chk("no_timeout", outs, P1U);
`endif

    // Asynchronous reset with a command pending.
    cmd(8'h04);
    chk("p2_down_set", outs, P2D | (outs & P1U));
    cmd(8'h10);
    chk("pause_before_rst", outs, Pau);
    send(8'hA5);
    @(posedge clk25MHz);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", outs, None);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("reset_quiet", outs, None);
    send(8'h04);
    cyc();
    chk("pending_abandoned", outs, None);
    cmd(8'h04);
    chk("post_reset_cmd", outs, P2D);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_paddle_ctrl.md
UART_PADDLE_CTRL -- requirements
Module: uart_paddle_ctrl

Interface
REQ-001 SHALL have parameter HOLD_FRAMES, default 4, meaning frame_ticks a movement output stays asserted after its last command (legal 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 25000, meaning clocks allowed between header byte and command byte (legal 1..65535).
REQ-003 SHALL have port clk25MHz  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port rx_data  input  8  received UART byte, valid only while rx_valid=1.
REQ-006 SHALL have port rx_valid  input  1  single-cycle strobe per received byte.
REQ-007 SHALL have port frame_tick  input  1  single-cycle strobe once per video frame.
REQ-008 SHALL have ports p1_up, p1_down, p2_up, p2_down  output  1 each  registered paddle movement requests.
REQ-009 SHALL have port pause  output  1  registered game-paused level.
REQ-010 SHALL have port game_reset  output  1  registered single-cycle restart pulse.
REQ-011 SHALL have port cmd_err  output  1  registered single-cycle protocol-error pulse.

Function
REQ-012 SHALL implement FSM WAIT_HDR, WAIT_CMD, EXEC; protocol is header 0xA5 followed by one command byte.
REQ-013 WAIT_HDR: rx_valid with 0xA5 -> WAIT_CMD; any other byte ignored, no error.
REQ-014 WAIT_CMD: rx_valid with 0xA5 -> stay in WAIT_CMD (resync), no error; any other byte latched -> EXEC.
REQ-015 EXEC SHALL last exactly one cycle, apply the latched command, then return to WAIT_HDR; outputs take new values on the edge leaving EXEC, i.e. visible 2 cycles after the command-byte strobe.
REQ-016 rx_valid during EXEC SHALL drop the byte and pulse cmd_err.
REQ-017 Commands: 0x01 P1 up, 0x02 P1 down, 0x03 P2 up, 0x04 P2 down, 0x10 toggle pause, 0x20 game reset; any other value pulses cmd_err with no other effect.
REQ-018 Each player SHALL have an 8-bit hold counter; a movement command loads HOLD_FRAMES, sets the commanded direction and clears the opposite one (up/down never both 1).
REQ-019 On frame_tick with counter >0, counter decrements; when it reaches 0 both direction outputs of that player clear on that same edge.
REQ-020 EXEC load and frame_tick in the same cycle: load wins, counter = HOLD_FRAMES.
REQ-021 While pause=1, movement commands SHALL be discarded without error, hold counters frozen and all movement outputs held at 0.
REQ-022 Pause toggle SHALL invert pause; on unpause, counters restart from 0 (outputs stay 0).
REQ-023 Game reset SHALL pulse game_reset for one cycle and in the same edge clear pause, both counters and all movement outputs.

Reset
REQ-024 rst_n=0 SHALL immediately force FSM to WAIT_HDR, counters to 0, all outputs to 0, latched command to 0x00.
REQ-025 Reset mid-frame (e.g. during WAIT_CMD or EXEC) SHALL abandon the pending command without any error or reset pulse.

Configuration
REQ-026 Macro CMD_TIMEOUT_EN defined: a 16-bit counter runs in WAIT_CMD, restarted on entry and on 0xA5 resync; after TIMEOUT_CYCLES clocks without rx_valid the FSM returns to WAIT_HDR and cmd_err pulses once.
REQ-027 Macro CMD_TIMEOUT_EN undefined: no timeout counter exists; WAIT_CMD waits indefinitely.

Verification
REQ-028 Bytes 0xA5,0x01 -> p1_up=1 two cycles after second strobe; 4 frame_ticks later p1_up=0.
REQ-029 0xA5,0x01 then 0xA5,0x02 before expiry -> p1_up=0, p1_down=1, counter reloaded to 4.
REQ-030 0xA5,0x10 then 0xA5,0x03 -> pause=1, p2_up stays 0; 0xA5,0x20 -> game_reset one-cycle pulse, pause=0.
REQ-031 0xA5,0x7F -> cmd_err one-cycle pulse, all other outputs unchanged; 0x33 alone in WAIT_HDR -> no response.
REQ-032 With CMD_TIMEOUT_EN, TIMEOUT_CYCLES=10: 0xA5 then silence -> cmd_err on 10th clock, following 0x01 ignored.
REQ-033 rst_n low while p2_down=1 and pause=1 -> all outputs 0 asynchronously; 0xA5,0x04 after release works normally.
